// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Bundles the command handshake, the ALU operand/result bus and the
//   accumulator/flag/done status of alu_sequencer.
//   slave  : the sequencer side (takes commands and ALU results, drives ALU
//            operands and status).
//   master : the environment side (control unit plus the combinational ALU).
interface alu_sequencer_if #(parameter int N = 8);
  logic         cmd_valid_in;
  logic         cmd_ready_out;
  logic [2:0]   cmd_op_in;
  logic [N-1:0] cmd_operand_in;

  logic [N-1:0] alu_a_out;
  logic [N-1:0] alu_b_out;
  logic [2:0]   alu_control_out;
  logic [N-1:0] alu_sum_in;
  logic         alu_carry_in;
  logic         alu_overflow_in;
  logic         alu_zero_in;

  logic [N-1:0] acc_out;
  logic         carry_flag_out;
  logic         overflow_flag_out;
  logic         zero_flag_out;
  logic         done_out;

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_operand_in,
    input  alu_sum_in, alu_carry_in, alu_overflow_in, alu_zero_in,
    output cmd_ready_out,
    output alu_a_out, alu_b_out, alu_control_out,
    output acc_out, carry_flag_out, overflow_flag_out, zero_flag_out, done_out
  );

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_operand_in,
    output alu_sum_in, alu_carry_in, alu_overflow_in, alu_zero_in,
    input  cmd_ready_out,
    input  alu_a_out, alu_b_out, alu_control_out,
    input  acc_out, carry_flag_out, overflow_flag_out, zero_flag_out, done_out
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accumulator-side initiator for the 8-bit combinational ALU. Accepts one
//   command per handshake, drives the ALU, and captures result and flags into
//   the accumulator and flag registers. MUL is an 8-step shift-add multiply
//   built from repeated ALU additions; the product is truncated to 8 bits.
// Ports
//   clk_in    : clock, rising edge
//   reset_in  : synchronous active-high reset
//   seq_if    : alu_sequencer_if.slave (command handshake, ALU bus, status)
//
// State table
//   state     | meaning
//   ST_IDLE   | ready for a command; ALU idles as acc + 0
//   ST_EXEC   | single-cycle op (LOAD/ADD/SUB/AND/OR/XOR/CMP) in flight
//   ST_MUL    | one shift-add step per cycle, 8 cycles total
//   ST_DONE   | one-cycle completion pulse
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic          clk_in,
  input  logic          reset_in,
  alu_sequencer_if.slave seq_if
);

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_CMP  = 3'd7;

  // bit0 doubles as carry-in and B-inversion select inside the ALU
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b011;
  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b100;
  localparam logic [2:0] CTL_XOR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] opr_q, opr_d;
  logic [N-1:0] acc_q, acc_d;
  logic         c_q, c_d;
  logic         v_q, v_d;
  logic         z_q, z_d;
  logic [N-1:0] prod_q, prod_d;
  logic [N-1:0] mcand_q, mcand_d;
  logic [N-1:0] mplier_q, mplier_d;
  logic [2:0]   cnt_q, cnt_d;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_ctl;
  logic [N-1:0] prod_nx;

  function automatic logic [2:0] ctl_for(input logic [2:0] op);
    case (op)
      OP_SUB, OP_CMP: ctl_for = CTL_SUB;
      OP_AND:         ctl_for = CTL_AND;
      OP_OR:          ctl_for = CTL_OR;
      OP_XOR:         ctl_for = CTL_XOR;
      default:        ctl_for = CTL_ADD;
    endcase
  endfunction

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opr_q    <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opr_q    <= opr_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opr_d    = opr_q;
    acc_d    = acc_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    alu_a    = acc_q;
    alu_b    = '0;
    alu_ctl  = CTL_ADD;
    prod_nx  = prod_q;

    case (state_q)
      ST_IDLE: begin
        if (seq_if.cmd_valid_in) begin
          op_d  = seq_if.cmd_op_in;
          opr_d = seq_if.cmd_operand_in;
          if (seq_if.cmd_op_in == OP_MUL) begin
            prod_d   = '0;
            mcand_d  = acc_q;
            mplier_d = seq_if.cmd_operand_in;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            state_d  = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        alu_b   = opr_q;
        alu_ctl = ctl_for(op_q);
        case (op_q)
          OP_LOAD: begin
            acc_d = opr_q;
            c_d   = 1'b0;
            v_d   = 1'b0;
            z_d   = (opr_q == '0);
          end
          OP_ADD, OP_SUB: begin
            acc_d = seq_if.alu_sum_in;
            c_d   = seq_if.alu_carry_in;
            v_d   = seq_if.alu_overflow_in;
            z_d   = seq_if.alu_zero_in;
          end
          OP_CMP: begin
            c_d   = seq_if.alu_carry_in;
            v_d   = seq_if.alu_overflow_in;
            z_d   = seq_if.alu_zero_in;
          end
          OP_AND, OP_OR, OP_XOR: begin
            acc_d = seq_if.alu_sum_in;
            c_d   = 1'b0;
            v_d   = 1'b0;
            z_d   = seq_if.alu_zero_in;
          end
          default: ;
        endcase
        state_d = ST_DONE;
      end

      ST_MUL: begin
        alu_a    = prod_q;
        alu_b    = mcand_q;
        prod_nx  = mplier_q[0] ? seq_if.alu_sum_in : prod_q;
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        // last step commits the product including this step's conditional add
        if (cnt_q == 3'd7) begin
          acc_d   = prod_nx;
          c_d     = 1'b0;
          v_d     = 1'b0;
          z_d     = (prod_nx == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign seq_if.cmd_ready_out     = (state_q == ST_IDLE);
  assign seq_if.done_out          = (state_q == ST_DONE);
  assign seq_if.alu_a_out         = alu_a;
  assign seq_if.alu_b_out         = alu_b;
  assign seq_if.alu_control_out   = alu_ctl;
  assign seq_if.acc_out           = acc_q;
  assign seq_if.carry_flag_out    = c_q;
  assign seq_if.overflow_flag_out = v_q;
  assign seq_if.zero_flag_out     = z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;

  alu_sequencer_if #(.N(8)) bus ();

  alu_sequencer #(.N(8)) dut (
    .clk_in   (clk),
    .reset_in (reset),
    .seq_if   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- combinational ALU model ----------------
  logic [8:0] alu_s;
  logic [7:0] alu_bx;
  always_comb begin
    alu_s  = '0;
    alu_bx = bus.alu_b_out;
    bus.alu_carry_in    = 1'b0;
    bus.alu_overflow_in = 1'b0;
    case (bus.alu_control_out)
      3'b000: alu_s = {1'b0, bus.alu_a_out & bus.alu_b_out};
      3'b100: alu_s = {1'b0, bus.alu_a_out | bus.alu_b_out};
      3'b110: alu_s = {1'b0, bus.alu_a_out ^ bus.alu_b_out};
      3'b010, 3'b011: begin
        alu_bx = bus.alu_control_out[0] ? ~bus.alu_b_out : bus.alu_b_out;
        alu_s  = {1'b0, bus.alu_a_out} + {1'b0, alu_bx} + {8'd0, bus.alu_control_out[0]};
        bus.alu_carry_in    = alu_s[8];
        bus.alu_overflow_in = (bus.alu_a_out[7] == alu_bx[7]) && (alu_s[7] != bus.alu_a_out[7]);
      end
      default: alu_s = '0;
    endcase
    bus.alu_sum_in  = alu_s[7:0];
    bus.alu_zero_in = (alu_s[7:0] == 8'd0);
  end

  // ---------------- behavioural reference model ----------------
  int m_acc, m_c, m_v, m_z;
  int p_acc, p_c, p_v, p_z;
  bit m_busy, m_done, m_take, chk_en;
  int cyc = 0;
  int m_fin;

  task automatic model_op(input int op, input int a, input int b,
                          output int r, output int c, output int v, output int z);
    int s;
    r = a; c = 0; v = 0;
    case (op)
      0: r = b;
      1: begin s = a + b; r = s % 256; c = (s > 255); v = (((a ^ r) & (b ^ r) & 128) != 0); end
      2, 7: begin
        s = a + (255 - b) + 1; c = (s > 255);
        v = (((a ^ b) & (a ^ (s % 256)) & 128) != 0);
        r = (op == 2) ? s % 256 : a;
        z = ((s % 256) == 0);
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a * b) % 256;
      default: r = a;
    endcase
    if (op != 7) z = (r == 0);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_acc = 0; m_c = 0; m_v = 0; m_z = 0;
      m_busy = 0; m_done = 0; chk_en = 1;
    end else begin
      m_take = !m_busy && bus.cmd_valid_in;
      if (m_busy && cyc == m_fin) begin
        m_acc = p_acc; m_c = p_c; m_v = p_v; m_z = p_z; m_done = 1;
      end else if (m_busy && cyc == m_fin + 1) begin
        m_busy = 0; m_done = 0;
      end
      if (m_take) begin
        model_op(int'(bus.cmd_op_in), m_acc, int'(bus.cmd_operand_in), p_acc, p_c, p_v, p_z);
        m_busy = 1;
        m_fin  = cyc + ((bus.cmd_op_in == 3'd6) ? 8 : 1);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("acc",   int'(bus.acc_out),           m_acc);
      chk("carry", int'(bus.carry_flag_out),    m_c);
      chk("ovf",   int'(bus.overflow_flag_out), m_v);
      chk("zero",  int'(bus.zero_flag_out),     m_z);
      chk("done",  int'(bus.done_out),          int'(m_done));
      chk("ready", int'(bus.cmd_ready_out),     int'(!m_busy));
      if (!m_busy) begin
        chk("idle_a",   int'(bus.alu_a_out),       m_acc);
        chk("idle_b",   int'(bus.alu_b_out),       0);
        chk("idle_ctl", int'(bus.alu_control_out), 2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [7:0] opr, input bit hold);
    int n;
    @(posedge clk); #1;
    bus.cmd_valid_in   = 1'b1;
    bus.cmd_op_in      = op;
    bus.cmd_operand_in = opr;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready_out && n < 40) begin @(negedge clk); n++; end
    chk("accept_seen", int'(bus.cmd_ready_out), 1);
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.done_out && lat < 20) begin @(negedge clk); lat++; end
    chk("done_seen", int'(bus.done_out), 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] opr, output int lat);
    issue(op, opr, 1'b0);
    wait_done(lat);
  endtask

  typedef struct { logic [2:0] op; logic [7:0] opr; logic [7:0] exp; } vec_t;
  vec_t vtab[4];

  initial begin
    int lat, n;
    reset = 1'b1;
    bus.cmd_valid_in = 1'b0;
    bus.cmd_op_in = 3'd0;
    bus.cmd_operand_in = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_acc",  int'(bus.acc_out), 0);
    chk("rst_ctl",  int'(bus.alu_control_out), 2);
    chk("rst_rdy",  int'(bus.cmd_ready_out), 1);
    chk("rst_done", int'(bus.done_out), 0);

    // overflow on ADD
    run(3'd0, 8'h7F, lat);
    run(3'd1, 8'h01, lat);
    chk("t1_lat", lat, 2);
    chk("t1_acc", int'(bus.acc_out), 8'h80);
    chk("t1_v", int'(bus.overflow_flag_out), 1);
    chk("t1_c", int'(bus.carry_flag_out), 0);
    chk("t1_z", int'(bus.zero_flag_out), 0);

    // carry wrap, CMP leaves acc alone
    run(3'd0, 8'hFF, lat);
    run(3'd1, 8'h01, lat);
    chk("t2_acc", int'(bus.acc_out), 8'h00);
    chk("t2_c", int'(bus.carry_flag_out), 1);
    chk("t2_z", int'(bus.zero_flag_out), 1);
    chk("t2_v", int'(bus.overflow_flag_out), 0);
    run(3'd0, 8'h05, lat);
    run(3'd7, 8'h06, lat);
    chk("t2_cmp_acc", int'(bus.acc_out), 8'h05);
    chk("t2_cmp_c", int'(bus.carry_flag_out), 0);
    chk("t2_cmp_z", int'(bus.zero_flag_out), 0);

    // multiply and truncation
    run(3'd0, 8'h0D, lat);
    run(3'd6, 8'h0B, lat);
    chk("t3_lat", lat, 9);
    chk("t3_acc", int'(bus.acc_out), 8'h8F);
    chk("t3_c", int'(bus.carry_flag_out), 0);
    chk("t3_v", int'(bus.overflow_flag_out), 0);
    run(3'd0, 8'h20, lat);
    run(3'd6, 8'h08, lat);
    chk("t3_trunc_acc", int'(bus.acc_out), 8'h00);
    chk("t3_trunc_z", int'(bus.zero_flag_out), 1);

    // logic ops clear C/V
    run(3'd0, 8'hFF, lat);
    run(3'd1, 8'h01, lat);
    run(3'd5, 8'hF0, lat);
    chk("t4_xor_acc", int'(bus.acc_out), 8'hF0);
    chk("t4_xor_c", int'(bus.carry_flag_out), 0);
    chk("t4_xor_v", int'(bus.overflow_flag_out), 0);
    run(3'd4, 8'h0F, lat);
    chk("t4_or_acc", int'(bus.acc_out), 8'hFF);
    run(3'd3, 8'h00, lat);
    chk("t4_and_acc", int'(bus.acc_out), 8'h00);
    chk("t4_and_z", int'(bus.zero_flag_out), 1);

    // valid held through a MUL: next command waits for IDLE
    run(3'd0, 8'h03, lat);
    issue(3'd6, 8'h05, 1'b1);
    bus.cmd_op_in = 3'd1;
    bus.cmd_operand_in = 8'h01;
    n = 1;
    @(negedge clk);
    while (!bus.cmd_ready_out && n < 30) begin @(negedge clk); n++; end
    chk("t5_ready_cycle", n, 10);
    @(posedge clk); #1 bus.cmd_valid_in = 1'b0;
    wait_done(lat);
    chk("t5_lat", lat, 2);
    chk("t5_acc", int'(bus.acc_out), 8'h10);

    // directed table starting from 0x9A
    vtab[0] = '{3'd2, 8'h1B, 8'h7F};
    vtab[1] = '{3'd1, 8'h81, 8'h00};
    vtab[2] = '{3'd4, 8'h55, 8'h55};
    vtab[3] = '{3'd6, 8'h03, 8'hFF};
    run(3'd0, 8'h9A, lat);
    for (int i = 0; i < 4; i++) begin
      run(vtab[i].op, vtab[i].opr, lat);
      chk($sformatf("tab%0d_acc", i), int'(bus.acc_out), int'(vtab[i].exp));
    end

    // reset during MUL step 4
    run(3'd0, 8'h07, lat);
    issue(3'd6, 8'h09, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_acc", int'(bus.acc_out), 0);
    chk("t6_c", int'(bus.carry_flag_out), 0);
    chk("t6_v", int'(bus.overflow_flag_out), 0);
    chk("t6_z", int'(bus.zero_flag_out), 0);
    chk("t6_rdy", int'(bus.cmd_ready_out), 1);
    for (int i = 0; i < 12; i++) begin
      chk("t6_no_done", int'(bus.done_out), 0);
      @(negedge clk);
    end
    run(3'd0, 8'h3C, lat);
    chk("t6_load_acc", int'(bus.acc_out), 8'h3C);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
